// File: rtl/seq_div8by4_if.sv
// Start/busy/done handshake bundle for the sequential divider.
// The master drives a request and operands; the slave returns the result.
interface seq_div8by4_if #(
  parameter int DW = 8,
  parameter int VW = 4
);
  logic          start;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          busy;
  logic          done;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          dz;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, dz
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, dz
  );
endinterface

// File: rtl/seq_div8by4.sv
// Restoring divider resolving one quotient bit per clock.
// Recovers an operand from a product of the companion 4-bit multiplier.
module seq_div8by4 #(
  parameter int DW = 8,
  parameter int VW = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_div8by4_if.slave bus
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t        state_q;
  state_t        state_d;

  logic [DW-1:0] dvd_q;
  logic [VW-1:0] dvs_q;
  logic [VW:0]   prem_q;
  logic [DW-1:0] quo_q;
  logic [CW-1:0] cnt_q;

  logic [DW-1:0] quotient_q;
  logic [VW-1:0] remainder_q;
  logic          dz_q;
  logic          done_q;

  logic [VW:0]   shifted;
  logic          fits;
  logic [VW:0]   prem_next;
  logic [DW-1:0] quo_next;

  logic          load_en;
  logic          iter_en;
  logic          fin_norm;
  logic          fin_dz;

  // The partial remainder stays below the divisor, so its top bit is
  // always clear before the shift and the VW+1 bit window never overflows.
  always_comb begin
    shifted   = {prem_q[VW-1:0], dvd_q[DW-1]};
    fits      = (shifted >= {1'b0, dvs_q});
    prem_next = fits ? (shifted - {1'b0, dvs_q}) : shifted;
    quo_next  = {quo_q[DW-2:0], fits};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    load_en  = 1'b0;
    iter_en  = 1'b0;
    fin_norm = 1'b0;
    fin_dz   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.divisor != '0) begin
            load_en = 1'b1;
            state_d = S_CALC;
          end else begin
            fin_dz  = 1'b1;
            state_d = S_FIN;
          end
        end
      end
      S_CALC: begin
        iter_en = 1'b1;
        if (cnt_q == '0) begin
          fin_norm = 1'b1;
          state_d  = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Results are written on the edge that enters FIN so they are already
  // valid for the whole cycle in which done is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_q       <= '0;
      dvs_q       <= '0;
      prem_q      <= '0;
      quo_q       <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dz_q        <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= fin_norm | fin_dz;
      if (load_en) begin
        dvd_q  <= bus.dividend;
        dvs_q  <= bus.divisor;
        prem_q <= '0;
        quo_q  <= '0;
        cnt_q  <= CW'(DW - 1);
      end
      if (iter_en) begin
        dvd_q  <= dvd_q << 1;
        prem_q <= prem_next;
        quo_q  <= quo_next;
        cnt_q  <= cnt_q - 1'b1;
      end
      if (fin_norm) begin
        quotient_q  <= quo_next;
        remainder_q <= prem_next[VW-1:0];
        dz_q        <= 1'b0;
      end
      if (fin_dz) begin
        quotient_q  <= '1;
        remainder_q <= '0;
        dz_q        <= 1'b1;
      end
    end
  end

  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = done_q;
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
  assign bus.dz        = dz_q;

endmodule

// File: doc/seq_div8by4.md
Name: seq_div8by4

Overview:
- Sequential restoring divider: inverse of the 4-bit multiplier. Takes an 8-bit product-width dividend and a 4-bit divisor; returns quotient and remainder.
- Sits beside the multiplier so an operand can be recovered from a product, for example 225 / 15 = 15.
- One quotient bit is resolved per clock.
- Uses a start/busy/done handshake and reports divide-by-zero.

Parameters:
- DW, 8, dividend and quotient width in bits.
- VW, 4, divisor and remainder width in bits (VW <= DW).

Ports:
- clk  input  1  sole clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a division; sampled only when busy=0.
- dividend  input  DW  numerator, unsigned; captured on the accepted start.
- divisor  input  VW  denominator, unsigned; captured on the accepted start.
- busy  output  1  high from the cycle after an accepted start until done is asserted, inclusive.
- done  output  1  single-cycle pulse: quotient, remainder and dz are valid.
- quotient  output  DW  unsigned quotient; held until the next done.
- remainder  output  VW  unsigned remainder; held until the next done.
- dz  output  1  divide-by-zero flag for the last result; held with the result.

Behaviour:
- Reset (rst_n=0, asynchronous, any state):
  - busy=0, done=0, quotient=0, remainder=0, dz=0.
  - FSM goes to IDLE.
  - Internal registers are cleared.
  - Any division in progress is abandoned with no done.
- FSM states: IDLE, CALC, FIN.
- IDLE:
  - start=1 with divisor!=0: capture dividend and divisor, clear the partial remainder (VW+1 bits), load bit counter = DW-1, go to CALC.
  - start=1 with divisor==0: go to FIN with dz pending.
  - start=0: stay in IDLE.
- CALC, one iteration per cycle, exactly DW cycles:
  - Shift the partial remainder left by 1 and bring in the current dividend MSB.
  - If partial remainder >= divisor: subtract the divisor and shift 1 into the quotient; else shift 0 in.
  - Decrement the counter. After the iteration at counter=0, go to FIN.
- FIN, one cycle:
  - Register the results and pulse done=1.
  - Normal case: quotient = working quotient, remainder = final partial remainder (always < divisor, so it fits VW bits), dz=0.
  - dz case: quotient = all ones (255), remainder = 0, dz=1.
  - Go to IDLE.
  - Outputs keep their values after done until the next FIN.
- Latency, with start accepted at edge N:
  - Normal case: done=1 during cycle N+DW+1 (cycle N+9 for DW=8).
  - dz case: done=1 during cycle N+1.
- busy=1 in CALC and FIN, 0 in IDLE.
- start while busy=1 (CALC or FIN) is ignored: no capture, no queueing. A start held high across FIN is accepted in the IDLE cycle that follows.
- Operand inputs are only sampled at acceptance; changing them mid-operation has no effect.
- Arithmetic is unsigned throughout; no rounding. Invariant for divisor!=0: quotient*divisor + remainder == dividend.
- Boundary cases:
  - dividend=0 gives quotient 0, remainder 0.
  - divisor=1 gives quotient = dividend, remainder 0 (full DW-bit quotient range).
  - dividend < divisor gives quotient 0, remainder = dividend.
- Reset asserted mid-CALC: outputs return to reset values immediately, with no glitch pulse on done. After release, the first start is accepted normally.

Test Plan:
- After reset release, start with 6/3, 20/4, 225/15, 0/8, 60/10 → done 9 cycles after each start; (q,r) = (2,0), (5,0), (15,0), (0,0), (6,0); dz=0; busy high for 9 cycles.
- 255/1 → q=255, r=0. 200/7 → q=28, r=4. 5/9 → q=0, r=5. 254/15 → q=16, r=14.
- 77/0 → done one cycle after start; dz=1, q=255, r=0. The next division, 77/7, gives q=11, r=0, dz=0.
- Start 100/3 (q=33, r=1), then pulse start with 9/9 at cycles 3 and 9 after acceptance → the second start is ignored. done fires once with q=33, r=1, and the outputs hold after done.
- Start 180/12, then drive rst_n low for 1 cycle at cycle 4 → all outputs go to 0 at once and no done appears. After release, 180/12 gives q=15, r=0.
- Exhaustive sweep of all 256×16 operand pairs, back-to-back starts → every result matches the / and % reference values, dz exactly when divisor=0, and the multiplier round-trip invariant holds.
